// File: rtl/pc_fetch_stage_pkg.sv
// Shared definitions for the PC/fetch stage: state encoding, reset PC, instruction width.
package pc_fetch_stage_pkg;

   localparam int          INSTR_W          = 32;
   localparam int          STATE_W          = 3;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef enum logic [STATE_W-1:0] {
      IDLE  = 3'd0,
      REQ   = 3'd1,
      WAIT  = 3'd2,
      HAVE  = 3'd3,
      FAULT = 3'd4
   } fetch_state_t;

   function automatic logic is_word_aligned(input logic [1:0] lsb);
      return lsb == 2'b00;
   endfunction

endpackage

// File: rtl/pc_fetch_stage_if.sv
// Fetch-stage bus: next-PC feedback, instruction-memory handshake and decode handshake.
// Perf counter signals exist only when FETCH_PERF_CNT_EN is defined.
interface pc_fetch_stage_if #(parameter int ADDR_W = 32);
   import pc_fetch_stage_pkg::*;

   logic [ADDR_W-1:0]  PC_Next;
   logic [ADDR_W-1:0]  PC;
   logic [ADDR_W-1:0]  PC_Plus_4;
   logic               Imem_Req_Valid;
   logic               Imem_Req_Ready;
   logic [ADDR_W-1:0]  Imem_Addr;
   logic               Imem_Resp_Valid;
   logic [INSTR_W-1:0] Imem_Resp_Data;
   logic [INSTR_W-1:0] Instr;
   logic               Instr_Valid;
   logic               Instr_Ready;
   logic               Fetch_Fault;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0]        Perf_Instr_Count;
   logic [31:0]        Perf_Stall_Count;
`endif

   modport master (
      input  PC_Next, Imem_Req_Ready, Imem_Resp_Valid, Imem_Resp_Data, Instr_Ready,
      output PC, PC_Plus_4, Imem_Req_Valid, Imem_Addr, Instr, Instr_Valid, Fetch_Fault
`ifdef FETCH_PERF_CNT_EN
      , output Perf_Instr_Count, Perf_Stall_Count
`endif
   );

   modport slave (
      output PC_Next, Imem_Req_Ready, Imem_Resp_Valid, Imem_Resp_Data, Instr_Ready,
      input  PC, PC_Plus_4, Imem_Req_Valid, Imem_Addr, Instr, Instr_Valid, Fetch_Fault
`ifdef FETCH_PERF_CNT_EN
      , input Perf_Instr_Count, Perf_Stall_Count
`endif
   );

endinterface

// File: rtl/pc_fetch_stage_perf_counters.sv
// Fetch performance counters: accepted instructions and memory-stall cycles, both wrapping.
// Instantiated only under FETCH_PERF_CNT_EN.
module fetch_perf_counters
   import pc_fetch_stage_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  fetch_state_t state,
   input  logic         req_ready,
   input  logic         instr_ready,
   output logic [31:0]  instr_count,
   output logic [31:0]  stall_count
);

   logic accept;
   logic stall;

   assign accept = (state == HAVE) && instr_ready;
   assign stall  = ((state == REQ) && !req_ready) || (state == WAIT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instr_count <= '0;
         stall_count <= '0;
      end else begin
         if (accept) instr_count <= instr_count + 32'd1;
         if (stall)  stall_count <= stall_count + 32'd1;
      end
   end

endmodule

// File: rtl/pc_fetch_stage.sv
// PC register and single-outstanding instruction-fetch sequencer (IDLE/REQ/WAIT/HAVE/FAULT).
// Optional FETCH_PERF_CNT_EN adds instruction and stall counters.
module pc_fetch_stage
   import pc_fetch_stage_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
)(
   input  logic             clk,
   input  logic             rst,
   pc_fetch_stage_if.master bus
);

   fetch_state_t       state;
   logic [ADDR_W-1:0]  pc;
   logic               req_valid;
   logic               instr_valid;
   logic               fault;
   logic [INSTR_W-1:0] instr;

   // Handshake outputs are registered so they toggle only with state changes;
   // the async reset clears them immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         pc          <= RESET_PC;
         req_valid   <= 1'b0;
         instr_valid <= 1'b0;
         fault       <= 1'b0;
         instr       <= '0;
      end else begin
         case (state)
            IDLE: begin
               state     <= REQ;
               req_valid <= 1'b1;
            end
            REQ: begin
               if (bus.Imem_Req_Ready) begin
                  state     <= WAIT;
                  req_valid <= 1'b0;
               end
            end
            WAIT: begin
               if (bus.Imem_Resp_Valid) begin
                  state       <= HAVE;
                  instr       <= bus.Imem_Resp_Data;
                  instr_valid <= 1'b1;
               end
            end
            HAVE: begin
               if (bus.Instr_Ready) begin
                  instr_valid <= 1'b0;
                  if (is_word_aligned(bus.PC_Next[1:0])) begin
                     state     <= REQ;
                     pc        <= bus.PC_Next;
                     req_valid <= 1'b1;
                  end else begin
                     state <= FAULT;
                     fault <= 1'b1;
                  end
               end
            end
            FAULT: begin
               state <= FAULT;
            end
            default: begin
               state       <= IDLE;
               req_valid   <= 1'b0;
               instr_valid <= 1'b0;
            end
         endcase
      end
   end

   assign bus.PC             = pc;
   assign bus.PC_Plus_4      = pc + ADDR_W'(4);
   assign bus.Imem_Addr      = pc;
   assign bus.Imem_Req_Valid = req_valid;
   assign bus.Instr          = instr;
   assign bus.Instr_Valid    = instr_valid;
   assign bus.Fetch_Fault    = fault;

`ifdef FETCH_PERF_CNT_EN
   fetch_perf_counters u_perf (
      .clk         (clk),
      .rst         (rst),
      .state       (state),
      .req_ready   (bus.Imem_Req_Ready),
      .instr_ready (bus.Instr_Ready),
      .instr_count (bus.Perf_Instr_Count),
      .stall_count (bus.Perf_Stall_Count)
   );
`endif

endmodule
